// File: rtl/rom_arbiter_pkg.sv
// Shared types for the instruction-ROM read-port arbiter and its response buffers.
package rom_arbiter_pkg;

  typedef enum logic {
    ROM_PORT_I = 1'b0,
    ROM_PORT_D = 1'b1
  } rom_port_e;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rom_resp_t;

  // Word access must be aligned and fall inside the ROM's word-address range.
  function automatic logic rom_addr_bad(logic [31:0] addr, int unsigned addr_length);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_length + 2)) != 32'h0);
  endfunction

endpackage

// File: rtl/rom_resp_fifo.sv
// 2-entry response buffer for one ROM requester.
// Latency: a push is visible on pop_dat the cycle after it is written.
// Backpressure: caller must not push when full unless popping in the same cycle.
module rom_resp_fifo
  import rom_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  rom_resp_t  push_dat,
  input  logic       pop,
  output rom_resp_t  pop_dat,
  output logic       pop_vld,
  output logic [1:0] occ
);

  rom_resp_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      // When full, push and pop share a slot: the head is read before the edge overwrites it.
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign pop_vld = (occ != 2'd0);
  assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rom_arbiter.sv
// Shares the ROM read port between fetch (I) and data-load (D) with per-port response buffers.
// Latency: request accepted in cycle N, response valid from cycle N+2.
// Backpressure: at most 2 outstanding accesses per port; req_ready drops when credits run out.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_LENGTH  = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] i_resp_data,
  output logic        i_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  output logic        d_resp_valid,
  input  logic        d_resp_ready,
  output logic [31:0] d_resp_data,
  output logic        d_resp_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;
  logic          infl_vld;
  rom_port_e     infl_port;
  logic          infl_err;

  logic       i_pop, d_pop, i_push, d_push;
  logic [1:0] i_occ, d_occ;
  logic [2:0] i_used, d_used;
  logic       i_elig, d_elig, i_gnt, d_gnt;
  logic       gnt_err;
  rom_resp_t  push_dat, i_head, d_head;

  assign i_pop = i_resp_valid && i_resp_ready;
  assign d_pop = d_resp_valid && d_resp_ready;

  // A pop this cycle frees a credit for a request in the same cycle.
  assign i_used = 3'(infl_vld && (infl_port == ROM_PORT_I)) + 3'(i_occ) - 3'(i_pop);
  assign d_used = 3'(infl_vld && (infl_port == ROM_PORT_D)) + 3'(d_occ) - 3'(d_pop);
  assign i_elig = i_req_valid && (i_used < 3'd2);
  assign d_elig = d_req_valid && (d_used < 3'd2);

  assign i_gnt = i_elig && ((starve_cnt == CW'(STARVE_LIMIT)) || !d_elig);
  assign d_gnt = d_elig && !i_gnt;

  assign i_req_ready = i_gnt;
  assign d_req_ready = d_gnt;
  assign rom_addr    = i_gnt ? i_req_addr : (d_gnt ? d_req_addr : 32'h0);
  assign gnt_err     = (i_gnt || d_gnt) && rom_addr_bad(rom_addr, ADDR_LENGTH);

  always_comb begin
    starve_nxt = starve_cnt;
    if (!i_elig || i_gnt) begin
      starve_nxt = '0;
    end else if (d_gnt && (starve_cnt != CW'(STARVE_LIMIT))) begin
      starve_nxt = starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      infl_vld   <= 1'b0;
      infl_port  <= ROM_PORT_I;
      infl_err   <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      infl_vld   <= i_gnt || d_gnt;
      infl_port  <= d_gnt ? ROM_PORT_D : ROM_PORT_I;
      infl_err   <= gnt_err;
    end
  end

  always_comb begin
    push_dat      = '0;
    push_dat.err  = infl_err;
    push_dat.data = infl_err ? 32'h0 : rom_data;
  end

  assign i_push = infl_vld && (infl_port == ROM_PORT_I);
  assign d_push = infl_vld && (infl_port == ROM_PORT_D);

  rom_resp_fifo u_i_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (i_push),
    .push_dat (push_dat),
    .pop      (i_pop),
    .pop_dat  (i_head),
    .pop_vld  (i_resp_valid),
    .occ      (i_occ)
  );

  rom_resp_fifo u_d_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (d_push),
    .push_dat (push_dat),
    .pop      (d_pop),
    .pop_dat  (d_head),
    .pop_vld  (d_resp_valid),
    .occ      (d_occ)
  );

  assign i_resp_data = i_head.data;
  assign i_resp_err  = i_head.err;
  assign d_resp_data = d_head.data;
  assign d_resp_err  = d_head.err;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter with a behavioural one-cycle-latency ROM.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready, i_resp_err;
  logic        d_req_valid, d_req_ready, d_resp_valid, d_resp_ready, d_resp_err;
  logic [31:0] i_req_addr, i_resp_data, d_req_addr, d_resp_data;
  logic [31:0] rom_addr, rom_data, rom_addr_q;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } sb_t;

  sb_t  qi[$];
  sb_t  qd[$];
  logic glog[$];          // 1 = I granted, 0 = D granted
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b1;
  logic [31:0] mem [1024];

  rom_arbiter #(.ADDR_LENGTH(10), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_ready  (i_req_ready),
    .i_req_addr   (i_req_addr),
    .i_resp_valid (i_resp_valid),
    .i_resp_ready (i_resp_ready),
    .i_resp_data  (i_resp_data),
    .i_resp_err   (i_resp_err),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_addr   (d_req_addr),
    .d_resp_valid (d_resp_valid),
    .d_resp_ready (d_resp_ready),
    .d_resp_data  (d_resp_data),
    .d_resp_err   (d_resp_err),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM: registers the word address every edge, data follows one cycle later.
  always @(posedge clk) rom_addr_q <= rom_addr;
  assign rom_data = mem[rom_addr_q[11:2]];

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'h5A00_0000 ^ (k * 32'h0001_0101);
    mem[4] = 32'hDEAD_BEEF;
  end

  function automatic sb_t expect_for(input logic [31:0] a, input int c);
    sb_t e;
    e.err  = (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
    e.data = e.err ? 32'h0 : mem[a[11:2]];
    e.cyc  = c;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Request tracker: records each transfer and its expected response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_req_valid && i_req_ready) begin
        qi.push_back(expect_for(i_req_addr, cyc));
        glog.push_back(1'b1);
      end
      if (d_req_valid && d_req_ready) begin
        qd.push_back(expect_for(d_req_addr, cyc));
        glog.push_back(1'b0);
      end
      if (i_req_ready && d_req_ready) begin
        total++; bad++;
        $display("FAIL double_grant: both ports granted at cycle %0d", cyc);
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin : mon
    sb_t e;
    if (rst_n) begin
      if (i_resp_valid && i_resp_ready) begin
        if (qi.size() == 0) begin
          total++; bad++;
          $display("FAIL i_unexpected: response %h at cycle %0d with none outstanding", i_resp_data, cyc);
        end else begin
          e = qi.pop_front();
          check("i_data", i_resp_data, e.data);
          check("i_err", {31'b0, i_resp_err}, {31'b0, e.err});
          if (lat_chk) check("i_latency", cyc - e.cyc, 32'd2);
        end
      end
      if (d_resp_valid && d_resp_ready) begin
        if (qd.size() == 0) begin
          total++; bad++;
          $display("FAIL d_unexpected: response %h at cycle %0d with none outstanding", d_resp_data, cyc);
        end else begin
          e = qd.pop_front();
          check("d_data", d_resp_data, e.data);
          check("d_err", {31'b0, d_resp_err}, {31'b0, e.err});
          if (lat_chk) check("d_latency", cyc - e.cyc, 32'd2);
        end
      end
    end
  end

  task automatic req_i(input logic [31:0] a);
    bit ok = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = i_req_ready;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL i_req_timeout: addr %h not accepted, ready=%b required 1", a, i_req_ready);
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic req_d(input logic [31:0] a);
    bit ok = 1'b0;
    d_req_valid = 1'b1;
    d_req_addr  = a;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = d_req_ready;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL d_req_timeout: addr %h not accepted, ready=%b required 1", a, d_req_ready);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (qi.size() != 0 || qd.size() != 0); k++) @(negedge clk);
    check("drain_i_left", qi.size(), 32'd0);
    check("drain_d_left", qd.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  initial begin
    int start;
    rst_n = 1'b0;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    i_req_addr = 32'h0; d_req_addr = 32'h0;
    i_resp_ready = 1'b1; d_resp_ready = 1'b1;
    #3;
    check("rst_i_resp_valid", {31'b0, i_resp_valid}, 32'd0);
    check("rst_d_resp_valid", {31'b0, d_resp_valid}, 32'd0);
    check("rst_i_resp_data", i_resp_data, 32'h0);
    check("rst_d_resp_data", d_resp_data, 32'h0);
    check("rst_i_resp_err", {31'b0, i_resp_err}, 32'd0);
    check("rst_d_resp_err", {31'b0, d_resp_err}, 32'd0);
    check("rst_rom_addr_idle", rom_addr, 32'h0);
    #9 rst_n = 1'b1;                                    // t=12, between edges
    #1 i_req_valid = 1'b1; d_req_valid = 1'b1; d_req_addr = 32'h20;
    #1;
    check("post_rst_d_priority", {30'b0, i_req_ready, d_req_ready}, 32'd1);
    check("post_rst_rom_addr", rom_addr, 32'h20);
    d_req_valid = 1'b0;
    #1;
    check("post_rst_i_eligible", {31'b0, i_req_ready}, 32'd1);
    i_req_valid = 1'b0;
    @(posedge clk); #1;

    // Single fetch of word 4 with exact timing.
    req_i(32'h0000_0010);
    @(negedge clk);
    check("single_n1_valid", {31'b0, i_resp_valid}, 32'd0);
    @(negedge clk);
    check("single_n2_valid", {31'b0, i_resp_valid}, 32'd1);
    check("single_n2_data", i_resp_data, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk); #1;

    // Misaligned and out-of-range accesses.
    req_i(32'h0000_0002);
    req_d(32'h0000_1000);
    req_d(32'h0000_0FFC);
    drain();

    // Full-rate streaming on I alone.
    start = cyc;
    for (int k = 0; k < 16; k++) req_i(32'h100 + 32'(4 * k));
    check("stream_cycles", cyc - start, 32'd16);
    drain();

    // Contention: both ports request continuously.
    glog.delete();
    fork
      for (int k = 0; k < 3; k++) req_i(32'h200 + 32'(4 * k));
      for (int k = 0; k < 12; k++) req_d(32'h300 + 32'(4 * k));
    join
    check("contention_grants", glog.size(), 32'd15);
    for (int k = 0; k < 15 && k < glog.size(); k++)
      check("contention_seq", {31'b0, glog[k]}, (k % 5 == 4) ? 32'd1 : 32'd0);
    drain();

    // Backpressure: D credits exhausted after two accepted requests.
    lat_chk = 1'b0;
    d_resp_ready = 1'b0;
    req_d(32'h40);
    req_d(32'h44);
    d_req_valid = 1'b1; d_req_addr = 32'h48;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_d_ready_low", {31'b0, d_req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    d_resp_ready = 1'b1;
    req_d(32'h48);
    drain();

    // Reset mid-flight: D and I each hold one buffered entry, a D access is in flight.
    i_resp_ready = 1'b0; d_resp_ready = 1'b0;
    req_d(32'h50);
    req_i(32'h54);
    req_d(32'h58);
    check("pre_rst_i_valid", {31'b0, i_resp_valid}, 32'd1);
    check("pre_rst_d_valid", {31'b0, d_resp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_i_valid", {31'b0, i_resp_valid}, 32'd0);
    check("async_rst_d_valid", {31'b0, d_resp_valid}, 32'd0);
    check("async_rst_d_data", d_resp_data, 32'h0);
    qi.delete(); qd.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    i_resp_ready = 1'b1; d_resp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    lat_chk = 1'b1;
    req_i(32'h0000_0010);
    req_d(32'h0000_0060);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
